song_reader: RTL and testbench

SONG_READER -- requirements
Module: song_reader

---
 rtl/song_reader.sv | 126 ++++++++++++
 tb/tb_song_reader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/song_reader.sv
// Song sequencer: walks up to 32 {note, duration} words of the selected song out of a
// synchronous ROM, handing each note to the player and waiting for it to finish.
module song_reader #(
  parameter int unsigned NOTE_W = 6,
  parameter int unsigned DUR_W  = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    play,
  input  logic                    reset_player,
  input  logic [1:0]              song,
  input  logic                    note_done,
  output logic [6:0]              rom_addr,
  input  logic [NOTE_W+DUR_W-1:0] rom_data,
  output logic [NOTE_W-1:0]       note,
  output logic [DUR_W-1:0]        duration,
  output logic                    new_note,
  output logic                    song_done
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StEmit,
    StWaitNote,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [4:0]        idx_q, idx_d;
  logic              pending_q, pending_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic              new_note_q, new_note_d;

  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0]  rom_dur;

  assign rom_note  = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur   = rom_data[DUR_W-1:0];

  // Song select feeds the address directly so a song change is seen by the next fetch.
  assign rom_addr  = {song, idx_q};
  assign note      = note_q;
  assign duration  = dur_q;
  assign new_note  = new_note_q;
  assign song_done = (state_q == StDone);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pending_d  = pending_q;
    note_d     = note_q;
    dur_d      = dur_q;
    new_note_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (play) state_d = StFetch;
      end
      StFetch: begin
        if (play) state_d = StEmit;
      end
      StEmit: begin
        if (play) begin
          if (rom_dur == '0) begin
            state_d = StDone;
          end else begin
            note_d     = rom_note;
            dur_d      = rom_dur;
            new_note_d = 1'b1;
            state_d    = StWaitNote;
          end
        end
      end
      StWaitNote: begin
        if (play && (note_done || pending_q)) begin
          pending_d = 1'b0;
          if (idx_q == 5'd31) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = StFetch;
          end
        end else if (note_done && !play) begin
          // Remember a finish that arrives while paused; consumed once play resumes.
          pending_d = 1'b1;
        end
      end
      StDone: begin
        idx_d     = 5'd0;
        pending_d = 1'b0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (reset_player) begin
      state_d    = StIdle;
      idx_d      = 5'd0;
      pending_d  = 1'b0;
      note_d     = '0;
      dur_d      = '0;
      new_note_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      idx_q      <= 5'd0;
      pending_q  <= 1'b0;
      note_q     <= '0;
      dur_q      <= '0;
      new_note_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      note_q     <= note_d;
      dur_q      <= dur_d;
      new_note_q <= new_note_d;
    end
  end

endmodule

// File: tb/tb_song_reader.sv
// Bench for song_reader: behavioural song ROM, note scoreboard and timing/corner checks.
module tb_song_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        play = 1'b0;
  logic        reset_player = 1'b0;
  logic [1:0]  song = 2'd0;
  logic        note_done = 1'b0;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data = '0;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        new_note;
  logic        song_done;

  logic [11:0] mem [128];
  logic [11:0] exp_q [$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          sd_count = 0;
  int          nn_count = 0;

  song_reader #(.NOTE_W(6), .DUR_W(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .play         (play),
    .reset_player (reset_player),
    .song         (song),
    .note_done    (note_done),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .note         (note),
    .duration     (duration),
    .new_note     (new_note),
    .song_done    (song_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= mem[rom_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] word(input int s, input int i);
    return mem[s*32 + i];
  endfunction

  always @(negedge clk) begin
    if (song_done) sd_count++;
    if (new_note) begin
      nn_count++;
      if (exp_q.size() == 0) begin
        check("spurious_new_note", 32'd1, 32'd0);
      end else begin
        logic [11:0] w;
        w = exp_q.pop_front();
        check("note", 32'(note), 32'(w[11:6]));
        check("duration", 32'(duration), 32'(w[5:0]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_new_note(input int budget, output int cycles);
    cycles = 0;
    while (cycles < budget) begin
      step();
      cycles++;
      if (new_note) return;
    end
    check("new_note_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_song_done(input int budget);
    int c = 0;
    while (c < budget) begin
      step();
      c++;
      if (song_done) return;
    end
    check("song_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_done();
    note_done = 1'b1;
    step();
    note_done = 1'b0;
  endtask

  initial begin
    int c;
    int nn_before;

    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 32; i++) begin
        mem[s*32 + i] = {6'((s*11 + i*3) % 63 + 1), 6'(i % 60 + 1)};
      end
    end
    mem[2*32 + 2][5:0] = 6'd0;

    // Asynchronous reset state, checked before any clock edge.
    #1 reset = 1'b1;
    #1;
    check("rst_note", 32'(note), 32'd0);
    check("rst_duration", 32'(duration), 32'd0);
    check("rst_new_note", 32'(new_note), 32'd0);
    check("rst_song_done", 32'(song_done), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'h00);
    repeat (3) step();
    reset = 1'b0;
    song  = 2'd1;
    step();

    // Song 1 from reset: first-note latency, then the whole 32-note song.
    play = 1'b1;
    exp_q.push_back(word(1, 0));
    check("rom_addr_s1", 32'(rom_addr), 32'h20);
    wait_new_note(10, c);
    check("first_latency", 32'(c), 32'd3);
    for (int i = 0; i < 32; i++) begin
      if (i > 0) wait_new_note(10, c);
      if (i < 31) exp_q.push_back(word(1, i + 1));
      pulse_done();
    end
    check("song_done_s1", 32'(song_done), 32'd1);
    play = 1'b0;
    step();
    check("song_done_one_cycle", 32'(song_done), 32'd0);
    check("rom_addr_s1_end", 32'(rom_addr), 32'h20);
    repeat (4) step();
    check("s1_note_count", 32'(nn_count), 32'd32);
    check("s1_song_done_count", 32'(sd_count), 32'd1);

    // Song 2: word 2 is the end marker.
    song = 2'd2;
    play = 1'b1;
    exp_q.push_back(word(2, 0));
    wait_new_note(10, c);
    exp_q.push_back(word(2, 1));
    pulse_done();
    wait_new_note(10, c);
    pulse_done();
    wait_song_done(8);
    play = 1'b0;
    step();
    check("rom_addr_s2_end", 32'(rom_addr), 32'h40);
    check("s2_note_held", 32'(note), 32'(mem[65][11:6]));
    repeat (4) step();
    check("s2_song_done_count", 32'(sd_count), 32'd2);
    check("s2_note_count", 32'(nn_count), 32'd34);

    // Song 0: pause in WAIT_NOTE with a finish arriving while paused.
    song = 2'd0;
    play = 1'b1;
    exp_q.push_back(word(0, 0));
    wait_new_note(10, c);
    play = 1'b0;
    pulse_done();
    nn_before = nn_count;
    repeat (5) step();
    check("paused_rom_addr", 32'(rom_addr), 32'h00);
    check("paused_no_note", 32'(nn_count), 32'(nn_before));
    play = 1'b1;
    exp_q.push_back(word(0, 1));
    wait_new_note(10, c);
    check("resume_latency", 32'(c), 32'd3);
    check("resume_rom_addr", 32'(rom_addr), 32'h01);

    // Walk to note 5 then clear during its fetch.
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) wait_new_note(10, c);
      if (i < 4) exp_q.push_back(word(0, i + 1));
      pulse_done();
    end
    check("fetch5_rom_addr", 32'(rom_addr), 32'h05);
    reset_player = 1'b1;
    play = 1'b0;
    step();
    reset_player = 1'b0;
    check("rp_note", 32'(note), 32'd0);
    check("rp_duration", 32'(duration), 32'd0);
    check("rp_new_note", 32'(new_note), 32'd0);
    check("rp_rom_addr", 32'(rom_addr), 32'h00);
    repeat (3) step();
    play = 1'b1;
    exp_q.push_back(word(0, 0));
    wait_new_note(10, c);
    check("rp_restart_latency", 32'(c), 32'd3);
    exp_q.push_back(word(0, 1));
    pulse_done();
    wait_new_note(10, c);

    // Async reset mid-cycle while new_note is high in WAIT_NOTE.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("ar_new_note", 32'(new_note), 32'd0);
    check("ar_note", 32'(note), 32'd0);
    check("ar_duration", 32'(duration), 32'd0);
    check("ar_rom_addr", 32'(rom_addr), 32'h00);
    play = 1'b0;
    step();
    reset = 1'b0;
    nn_before = nn_count;
    repeat (6) step();
    check("ar_idle_no_note", 32'(nn_count), 32'(nn_before));
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
